// File: rtl/dcache_responder_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        WB    = 2'd2,
        ALLOC = 2'd3
    } dcache_state_t;

    localparam int LINE_W   = 256;
    localparam int S_OFFSET = 5;

    function automatic int tag_width(input int s_index);
        return 32 - s_index - S_OFFSET;
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU data port plus physical-memory line port of the data cache.
interface dcache_responder_if;
    logic         data_read;
    logic         data_write;
    logic [3:0]   data_mbe;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic         data_resp;
    logic [31:0]  data_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache_responder_array.sv
// Cache storage: line data, tags, valid and dirty bits; async read, sync write.
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int TAG_W   = tag_width(S_INDEX)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [S_INDEX-1:0] idx_i,
    input  logic [31:0]        byte_we_i,
    input  logic [LINE_W-1:0]  wline_i,
    input  logic               load_i,
    input  logic [LINE_W-1:0]  load_line_i,
    input  logic [TAG_W-1:0]   load_tag_i,
    input  logic               set_dirty_i,
    input  logic               clr_dirty_i,
    output logic [LINE_W-1:0]  line_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o
);
    localparam int SETS = 1 << S_INDEX;

    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    // Line data and tag storage; a full-line load overrides byte writes.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_q[idx_i] <= load_line_i;
            tag_q[idx_i]  <= load_tag_i;
        end else begin
            for (int b = 0; b < 32; b++) begin
                if (byte_we_i[b]) begin
                    data_q[idx_i][b*8 +: 8] <= wline_i[b*8 +: 8];
                end
            end
        end
    end

    // Valid/dirty state, the only storage that reset touches.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (load_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    assign line_o  = data_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
endmodule

// File: rtl/dcache_responder_chk.sv
// Protocol properties of the data cache ports (simulation only).
module dcache_responder_chk (
    input logic clk,
    input logic rst,
    input logic data_read,
    input logic data_write,
    input logic data_resp,
    input logic pmem_read,
    input logic pmem_write
);
    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
        !(data_read && data_write));

    a_resp_single_pulse: assert property (@(posedge clk) disable iff (!rst)
        data_resp |=> !data_resp);

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(pmem_read && pmem_write));
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache: CPU-port FSM, hit detection and byte merge.
module dcache_responder
    import dcache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input logic               clk,
    input logic               rst,
    dcache_responder_if.slave bus
);
    localparam int TAG_W = tag_width(S_INDEX);

    dcache_state_t      state_q, state_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic [S_INDEX-1:0] req_idx_q, req_idx_d;

    logic               req_s, hit_s;
    logic [TAG_W-1:0]   cpu_tag_s, arr_tag_s;
    logic [S_INDEX-1:0] cpu_idx_s, arr_idx_s;
    logic [2:0]         word_s;
    logic [LINE_W-1:0]  line_s;
    logic               valid_s, dirty_s;
    logic [31:0]        byte_we_s;
    logic               set_dirty_s, clr_dirty_s, load_s;
    logic               unused_ok_s;

    assign req_s       = bus.data_read | bus.data_write;
    assign cpu_tag_s   = bus.data_addr[31:S_INDEX+S_OFFSET];
    assign cpu_idx_s   = bus.data_addr[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign word_s      = bus.data_addr[4:2];
    assign unused_ok_s = ^bus.data_addr[1:0];
    // Outside IDLE the latched miss index drives the array so a dropped request cannot redirect a fill.
    assign arr_idx_s   = (state_q == IDLE) ? cpu_idx_s : req_idx_q;
    assign hit_s       = valid_s && (arr_tag_s == cpu_tag_s);

    dcache_array #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_array (
        .clk_i       (clk),
        .rst_ni      (rst),
        .idx_i       (arr_idx_s),
        .byte_we_i   (byte_we_s),
        .wline_i     ({8{bus.data_wdata}}),
        .load_i      (load_s),
        .load_line_i (bus.pmem_rdata),
        .load_tag_i  (req_tag_q),
        .set_dirty_i (set_dirty_s),
        .clr_dirty_i (clr_dirty_s),
        .line_o      (line_s),
        .tag_o       (arr_tag_s),
        .valid_o     (valid_s),
        .dirty_o     (dirty_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rdata_q   <= 32'h0000_0000;
            paddr_q   <= 32'h0000_0000;
            req_tag_q <= '0;
            req_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            paddr_q   <= paddr_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
        end
    end

    // Next-state, array write controls and miss bookkeeping.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        paddr_d     = paddr_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        byte_we_s   = 32'h0000_0000;
        set_dirty_s = 1'b0;
        clr_dirty_s = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && hit_s) begin
                    if (bus.data_write) begin
                        byte_we_s   = {28'h000_0000, bus.data_mbe} << {word_s, 2'b00};
                        set_dirty_s = |bus.data_mbe;
                    end else begin
                        rdata_d = line_s[{word_s, 5'b00000} +: 32];
                    end
                    state_d = RESP;
                end else if (req_s) begin
                    req_tag_d = cpu_tag_s;
                    req_idx_d = cpu_idx_s;
                    if (valid_s && dirty_s) begin
                        paddr_d = {arr_tag_s, cpu_idx_s, 5'b00000};
                        state_d = WB;
                    end else begin
                        paddr_d = {cpu_tag_s, cpu_idx_s, 5'b00000};
                        state_d = ALLOC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            WB: begin
                if (bus.pmem_resp) begin
                    clr_dirty_s = 1'b1;
                    paddr_d     = {req_tag_q, req_idx_q, 5'b00000};
                    state_d     = ALLOC;
                end else begin
                    state_d = WB;
                end
            end
            ALLOC: begin
                if (bus.pmem_resp) begin
                    load_s  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ALLOC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_resp  = (state_q == RESP);
    assign bus.data_rdata = rdata_q;
    assign bus.pmem_read  = (state_q == ALLOC);
    assign bus.pmem_write = (state_q == WB);
    assign bus.pmem_addr  = paddr_q;
    assign bus.pmem_wdata = line_s;

    dcache_responder_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .data_read  (bus.data_read),
        .data_write (bus.data_write),
        .data_resp  (bus.data_resp),
        .pmem_read  (bus.pmem_read),
        .pmem_write (bus.pmem_write)
    );
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back data cache that answers the CPU data port: data_read/data_write/data_mbe/data_addr/data_wdata in, data_resp/data_rdata out.
- It is the responder for that port.
- On a miss it initiates 256-bit line transfers on the physical-memory (arbiter) side.
- It sits between cpu_datapath's D-port and the memory arbiter.

Parameters:
S_INDEX, 3, index bits; 2^S_INDEX sets (8 by default)
S_OFFSET, 5, byte-offset bits; line = 32 bytes = 256 bits (fixed; only value supported)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-low reset (rst==0 resets at the clock edge)
data_read  in  1  CPU read request; held with data_addr until data_resp
data_write  in  1  CPU write request; held with data_addr/data_wdata/data_mbe until data_resp
data_mbe  in  4  byte enables for writes
data_addr  in  32  word address; bits [1:0] ignored
data_wdata  in  32  write data
data_resp  out  1  one-cycle completion pulse
data_rdata  out  32  read data, valid while data_resp==1
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  line writeback request, held until pmem_resp
pmem_addr  out  32  line address, bits [4:0]=0
pmem_wdata  out  256  writeback line
pmem_rdata  in  256  fill line, valid when pmem_resp==1
pmem_resp  in  1  one-cycle transfer completion

Behaviour:
- Address split: tag = addr[31:S_INDEX+5], index = addr[S_INDEX+4:5], word = addr[4:2].
- Reset (rst==0):
  - state=IDLE; all valid and dirty bits cleared.
  - data_resp, pmem_read, pmem_write = 0; data_rdata = 0; pmem_addr = 0.
  - Data/tag array contents are don't-care.
- IDLE, no request: stay.
- IDLE, request, combinational tag compare:
  - Hit: on the edge, a read latches the word into data_rdata; a write merges data_wdata bytes where data_mbe=1 into the word and sets dirty (dirty unchanged if data_mbe=0000). Go to RESP.
  - Miss, dirty: go to WB.
  - Miss, clean or invalid: go to ALLOC.
- RESP: data_resp=1 for exactly this cycle, then IDLE. Hit latency is request seen in IDLE at cycle N, data_resp at cycle N+1.
  - Back-to-back requests are served at most one per 2 cycles.
  - data_resp is never high on two consecutive cycles.
- WB:
  - pmem_write=1, pmem_addr={stored tag,index,5'b0}, pmem_wdata=stored line.
  - On pmem_resp: clear dirty, go to ALLOC.
- ALLOC:
  - pmem_read=1, pmem_addr={req tag,index,5'b0}.
  - On pmem_resp: write pmem_rdata to the line, set tag, valid=1, dirty=0, go to IDLE.
  - The re-lookup then hits. Miss latency = 1 + WB cycles + ALLOC cycles + 1.
- Both data_read and data_write high is illegal. The write takes priority; simulation-only assertion fires.
- pmem_resp outside WB/ALLOC is ignored.
- Requests dropped mid-miss are a protocol violation. The fill still completes, and data_resp follows only if the request is present in IDLE.
- pmem_read and pmem_write are never high together.
- Reset mid-WB/ALLOC: the request deasserts on the next cycle and the partial line is never validated. The line refills on the next access.

Decomposition:
- Package dcache_types:
  - dcache_state_t enum {IDLE, RESP, WB, ALLOC}.
  - Constants LINE_W=256, S_OFFSET=5.
  - Tag-width function of S_INDEX.
- Sub-module dcache_array holds the storage:
  - Data, tag, valid and dirty arrays.
  - Synchronous write with per-byte write enable (32 bits) and full-line load.
  - Asynchronous read.
- dcache_responder contains the FSM, hit logic and byte merge.

Test Plan:
1. Fill line data: after reset, read 0x0000_0048 and answer the fill with a line whose word i = 0x1000_000i.
   - pmem_read with pmem_addr=0x40 and no pmem_write.
   - data_resp with data_rdata=0x1000_0002.
2. Hit read: read 0x0000_004C immediately after test 1.
   - data_resp exactly 1 cycle after the request, data_rdata=0x1000_0003.
   - pmem_read and pmem_write stay 0.
3. Byte-merge write: write 0x48 with data_mbe=0011 and data_wdata=0xAAAA_BBBB, then read 0x48.
   - The read returns 0x1000_BBBB.
4. Conflict eviction: read 0x0000_0140 (same index 2, different tag).
   - pmem_write at pmem_addr=0x40 with pmem_wdata word2=0x1000_BBBB.
   - After pmem_resp, pmem_read at 0x140, then data_resp with the new data.
5. Reset during ALLOC: rst=0 while pmem_read=1 and pmem_resp is never given.
   - Next cycle pmem_read=0 and data_resp=0.
   - A later read of 0x48 misses and refills.
6. Back-to-back hits: hold 4 consecutive read requests to the same line.
   - data_resp pulses every other cycle with the correct words.
   - data_resp is never high on 2 consecutive cycles.
